// File: rtl/parity_check.sv
// Serial-bit parity checker.
// Samples one bit of x per rising clock edge and tracks the running parity
// of every bit received since the last reset (or since power-up). The
// tracker is a two-state Moore machine (EVEN/ODD). z flags odd parity, or
// even parity when INVERT_OUT is set. Both the state and z are registers,
// so there is no combinational path from x to z. A bit sampled at edge N
// appears on z just after edge N and holds for the whole following cycle.
module parity_check #(
  parameter bit INVERT_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // Power-up values match the reset state, so z is valid before the first
  // reset. INVERT_OUT only changes the output polarity, not the state
  // encoding.
  state_t state = EVEN;
  logic   z_reg = INVERT_OUT;

  // Output flag for a given state, with the optional polarity inversion.
  function automatic logic flag_of(input state_t s);
    return (s == ODD) ^ INVERT_OUT;
  endfunction

  // Next state: a 1 flips the parity and a 0 keeps it (state XOR x).
  function automatic state_t step(input state_t s, input logic bit_in);
    state_t n;
    n = s;
    if (bit_in) begin
      n = (s == EVEN) ? ODD : EVEN;
    end
    return n;
  endfunction

  // Parity FSM with a registered Moore output. z is loaded from the same
  // next-state value as the state register, so it always equals
  // flag_of(state) without decoding state after the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN;
      z_reg <= flag_of(EVEN);
    end else begin
      state <= step(state, x);
      z_reg <= flag_of(step(state, x));
    end
  end

  assign z = z_reg;

endmodule

// File: tb/tb_parity_check.sv
// Testbench for parity_check.
// Runs two instances side by side on shared stimulus: INVERT_OUT=0 and
// INVERT_OUT=1. The first part is a table of directed vectors. It is
// followed by a hand-written sequence on output timing and then by a
// random stream checked against a count-of-ones reference model.
module tb_parity_check;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x   = 1'b0;
  logic z0;
  logic z1;

  int n_checks = 0;
  int n_fail   = 0;

  parity_check #(.INVERT_OUT(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .z  (z0)
  );

  parity_check #(.INVERT_OUT(1'b1)) dut1 (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .z  (z1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic x;
    logic z;   // expected z of the INVERT_OUT=0 instance after the edge
  } vec_t;

  vec_t vecs[$];

  // Append one vector to the table.
  function automatic void add(input logic r, input logic xi, input logic ze);
    vec_t v;
    v.rst = r;
    v.x   = xi;
    v.z   = ze;
    vecs.push_back(v);
  endfunction

  // Compare one value, count it, and report any difference.
  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, then sample #1 after the rising edge.
  task automatic apply(input logic r, input logic xi);
    @(negedge clk);
    rst = r;
    x   = xi;
    @(posedge clk);
    #1;
  endtask

  int   ones;
  logic exp_z;
  logic z0_hold;
  logic z1_hold;

  initial begin
    // Stream from the power-up state, with no reset applied.
    add(0,0,0); add(0,1,1); add(0,0,1); add(0,1,0);
    add(0,0,0); add(0,1,1); add(0,1,0); add(0,0,0);
    add(0,0,0); add(0,1,1); add(0,1,0); add(0,0,0);
    // Reset in mid-stream. x=1 is ignored on the reset edge.
    add(0,1,1); add(1,1,0); add(0,1,1);
    // Reset held for several edges with x toggling.
    add(1,1,0); add(1,0,0); add(1,1,0);
    // All zeros after reset.
    for (int i = 0; i < 20; i++) add(0,0,0);
    // All ones after reset. z toggles.
    add(1,1,0);
    for (int i = 0; i < 8; i++) add(0,1,((i % 2) == 0) ? 1'b1 : 1'b0);
    // Inverted-output sequence, seen on dut1 as ~z: 1, 0, 0, 1.
    add(1,0,0); add(0,1,1); add(0,0,1); add(0,1,0);

    // Power-up values, before any clock edge.
    #1;
    check("powerup_z0", z0, 1'b0);
    check("powerup_z1", z1, 1'b1);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].x);
      check($sformatf("vec%0d_z0", i), z0, vecs[i].z);
      check($sformatf("vec%0d_z1", i), z1, ~vecs[i].z);
    end

    // Output timing: toggle x between edges. z may change only at rising edges.
    apply(1'b1, 1'b0);
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      // x toggles several times within one cycle.
      // Only the value present at the next edge counts.
      @(negedge clk);
      rst = 1'b0;
      z0_hold = z0;
      z1_hold = z1;
      x = 1'b1;
      #1;
      check("midcycle_z0_a", z0, z0_hold);
      check("midcycle_z1_a", z1, z1_hold);
      x = 1'b0;
      #1;
      check("midcycle_z0_b", z0, z0_hold);
      x = (i % 2 == 0) ? 1'b1 : 1'b0;
      #2;
      check("midcycle_z0_c", z0, z0_hold);
      check("midcycle_z1_c", z1, z1_hold);
      @(posedge clk);
      #1;
      if (x) ones++;
      exp_z = ones[0];
      check("timing_edge_z0", z0, exp_z);
      check("timing_edge_z1", z1, ~exp_z);
    end

    // Random stream: the model counts the ones seen since the last reset.
    apply(1'b1, 1'b1);
    ones = 0;
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic xi;
      r  = ($urandom_range(0, 19) == 0);
      xi = $urandom_range(0, 1);
      apply(r, xi);
      if (r) ones = 0;
      else if (xi) ones++;
      exp_z = (ones % 2 == 1);
      check("random_z0", z0, exp_z);
      check("random_z1", z1, ~exp_z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
